fifo_read_stream: RTL and testbench
===================================

# fifo_read_stream

Read-side adapter in the clk_a domain that drains the read port of an async FIFO carrying traffic from the B domain back to A, converting its registered-read interface (empty / rd_en / dout valid one cycle later) into a ready/valid stream. It holds a small circular skid buffer so the stream sustains one word per cycle while `fifo_rd_en` stays free of any combinational path from `m_ready`. It sits between the FIFO's read port and any A-side consumer.

## Interface
- `DATA_WIDTH`, 4, payload width; matches the FIFO data width.
- `BUF_DEPTH`, 3, skid buffer entries; legal minimum 3, which is required for full throughput without a ready-to-rd_en path.
- `clk_a`  in  1  clock.
- `rst_a`  in  1  reset; asynchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag, already valid in the clk_a domain.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  FIFO read request.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  stream valid.
- `m_data`  out  DATA_WIDTH  stream payload.
- `m_ready`  in  1  stream ready.
- `buf_count`  out  $clog2(BUF_DEPTH+1)  current buffer occupancy.

## Operation
- State: buffer array, `wr_ptr`/`rd_ptr` (mod BUF_DEPTH, explicit wrap at BUF_DEPTH-1 → 0), `count` 0..BUF_DEPTH, `inflight` bit.
- Issue rule: `fifo_rd_en = rst_a & !flush & !fifo_empty & (count + inflight < BUF_DEPTH)`. Uses registered state only; never depends on `m_ready`.
- Accepted read: `inflight <= fifo_rd_en`. On the next edge, if `inflight` is set and no flush is active, `fifo_dout` is written to `buf[wr_ptr]`, `wr_ptr` advances, and `count` increments.
- Pop: a pop occurs when `m_valid & m_ready`. `rd_ptr` advances and `count` decrements.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `m_valid = (count != 0)` and `m_data = buf[rd_ptr]`. Both are driven straight from registers and the array; there is no bypass from `fifo_dout`.
- Flush:
  - On the edge with `flush=1`: `count`, both pointers, and `inflight` clear to 0.
  - A word returning from a read issued the cycle before the flush is dropped.
  - `fifo_rd_en` is 0 during the flush cycle.
  - A pop presented in the flush cycle is ignored (no handshake credited).
- Stream rules: once `m_valid` is asserted, `m_data` holds stable until the pop. The only way to retract `m_valid` is a flush.
- Overflow is impossible by construction. A push into a full buffer is a verification assertion failure.

## Timing
- Reset values: `m_valid=0`, `m_data=0` (array cleared), `fifo_rd_en=0`, `buf_count=0`, `inflight=0`, pointers 0.
- First-word latency: `fifo_rd_en` high in cycle N, `fifo_dout` sampled at the end of N+1, `m_valid` high in N+2.
- Throughput: one word per cycle when the FIFO stays non-empty and `m_ready` is held high. Steady state is `count` ≤ 1 with `inflight` = 1.
- Back-pressure: after `m_ready` drops, at most BUF_DEPTH words accumulate, then `fifo_rd_en` deasserts. It reasserts the cycle after the first pop brings `count + inflight` below BUF_DEPTH.
- `fifo_empty` rising while a read is in flight: the in-flight word is still captured and no further reads issue.
- Reset mid-operation: all state clears immediately (asynchronous). Any FIFO word in flight is lost; the upstream FIFO resets together with this block.

## Structure
- Shared package `async_fifo_pkg`: constant `MIN_SKID_DEPTH = 3`, and function `ptr_inc(ptr, depth)` for wrapping pointer increment, reused by the FIFO handlers.
- One sub-module, `stream_skid_buf`: circular buffer with push/pop/flush and count. The top level adds the issue logic, the `inflight` tracking, and the FIFO port.
- Elaboration-time check: BUF_DEPTH ≥ MIN_SKID_DEPTH.

## Test plan
- Streaming: FIFO preloaded with 0x1..0x8, `m_ready=1` → words 0x1..0x8 appear in order on consecutive cycles. First `m_valid` is 2 cycles after the first `fifo_rd_en`.
- Back-pressure: `m_ready=0` for 10 cycles with the FIFO holding 6 words → exactly 3 reads issue, `buf_count=3`, and `m_data` is stable at the first word. After release, the remaining order is intact.
- Random ready: `m_ready` toggled randomly over 200 words → no loss or duplication, `fifo_rd_en` never asserted while `fifo_empty=1`, and `buf_count` ≤ 3.
- Flush with a read in flight: `flush` in the cycle after `fifo_rd_en` → the returning word is dropped, `m_valid=0` the next cycle, `buf_count=0`. The next FIFO word is delivered normally.
- Wrap-around: 7 push/pop cycles with partial back-pressure → pointers wrap 2→0 correctly and the data sequence is unchanged.
- Async reset asserted with `buf_count=2` and a read in flight → outputs are 0 immediately. After deassert, the first word is delivered with a fresh 2-cycle latency.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async FIFO read/write handlers.
// Pointer wrap is explicit so non-power-of-two depths work.
package async_fifo_pkg;

  localparam int MIN_SKID_DEPTH = 3;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_read_stream_if.sv
// Ready/valid stream carrying FIFO words into the A-side consumer.
interface fifo_read_stream_if #(
  parameter int DATA_WIDTH = 4
);

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_read_stream_skid_buf.sv
// Circular skid buffer with push/pop/flush; the head entry is presented
// straight from the array so the output is register-driven.
module stream_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 4,
  parameter int  BUF_DEPTH  = 3,
  localparam int PTR_W      = $clog2(BUF_DEPTH),
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_a,
  input  logic                  rst_a,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  always_ff @(posedge clk_a or negedge rst_a) begin
    if (!rst_a) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Contents are left in place; they are unreachable once count is 0.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= PTR_W'(ptr_inc(int'(wr_ptr), BUF_DEPTH));
      end
      if (pop) begin
        rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), BUF_DEPTH));
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign pop_data = mem[rd_ptr];

  overflow_a: assert property (@(posedge clk_a) disable iff (!rst_a)
    !(push && !flush && (count == CNT_W'(BUF_DEPTH))));

  underflow_a: assert property (@(posedge clk_a) disable iff (!rst_a)
    !(pop && !flush && (count == '0)));

endmodule

// File: rtl/fifo_read_stream.sv
// Drains a registered-read async FIFO port into a ready/valid stream.
// Read issue depends only on registered occupancy, never on m_ready.
module fifo_read_stream
  import async_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 4,
  parameter int  BUF_DEPTH  = 3,
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_a,
  input  logic                  rst_a,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  fifo_read_stream_if.master    stream,
  output logic [CNT_W-1:0]      buf_count
);

  if (BUF_DEPTH < MIN_SKID_DEPTH) begin : g_depth_check
    $error("fifo_read_stream: BUF_DEPTH must be at least MIN_SKID_DEPTH");
  end

  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             push;
  logic             pop;

  // Reserve a slot for every read that has not yet landed.
  assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en = rst_a & ~flush & ~fifo_empty
                    & (occupancy < (CNT_W + 1)'(BUF_DEPTH));

  // Issue stage -> capture stage: fifo_dout is valid one cycle after rd_en.
  always_ff @(posedge clk_a or negedge rst_a) begin
    if (!rst_a) begin
      inflight <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  assign push = inflight & ~flush;
  assign pop  = stream.m_valid & stream.m_ready & ~flush;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk_a     (clk_a),
    .rst_a     (rst_a),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_dout),
    .pop       (pop),
    .pop_data  (stream.m_data),
    .count     (count)
  );

  assign stream.m_valid = (count != '0);
  assign buf_count      = count;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Self-checking bench: behavioural FIFO + scoreboard around fifo_read_stream.
module tb_fifo_read_stream;

  localparam int DW = 4;
  localparam int BD = 3;
  localparam int CW = $clog2(BD + 1);

  logic          clk_a = 1'b0;
  logic          rst_a;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          flush;
  logic [CW-1:0] buf_count;

  fifo_read_stream_if #(.DATA_WIDTH(DW)) sif ();

  fifo_read_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk_a      (clk_a),
    .rst_a      (rst_a),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .stream     (sif.master),
    .buf_count  (buf_count)
  );

  always #5 clk_a = ~clk_a;

  // Behavioural registered-read FIFO
  logic [DW-1:0] fifo_q[$];
  int n_loaded = 0;
  int n_read = 0;
  int rd_empty_viol = 0;
  assign fifo_empty = (n_loaded == n_read);

  always @(posedge clk_a or negedge rst_a) begin
    if (!rst_a) begin
      fifo_dout <= '0;
    end else if (fifo_rd_en) begin
      if (fifo_q.size() == 0) rd_empty_viol++;
      else begin
        fifo_dout <= fifo_q.pop_front();
        n_read    <= n_read + 1;
      end
    end
  end

  // Scoreboard and per-cycle observations
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic [DW-1:0] next_word = 4'h1;
  int cyc = 0, first_rd = -1, first_vld = -1, max_count = 0, rd_cnt = 0;
  int rd_viol = 0, stab_viol = 0;
  logic s_valid, s_rd_en, s_empty;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_count;
  logic prev_valid = 0, prev_pop = 0, prev_fl = 0;
  logic [DW-1:0] prev_data = '0;
  int n_checks = 0, n_fail = 0;

  task automatic cycle(input logic rdy, input logic fl, input int nload);
    @(negedge clk_a);
    for (int i = 0; i < nload; i++) begin
      fifo_q.push_back(next_word);
      exp_q.push_back(next_word);
      next_word = next_word + 4'h1;
      n_loaded++;
    end
    sif.m_ready = rdy;
    flush = fl;
    #1;
    s_valid = sif.m_valid;
    s_data  = sif.m_data;
    s_rd_en = fifo_rd_en;
    s_empty = fifo_empty;
    s_count = buf_count;
    if (s_rd_en && s_empty) rd_viol++;
    if (s_rd_en) rd_cnt++;
    if (s_rd_en && first_rd < 0) first_rd = cyc;
    if (s_valid && first_vld < 0) first_vld = cyc;
    if (int'(s_count) > max_count) max_count = int'(s_count);
    if (prev_valid && !prev_pop && !prev_fl && (!s_valid || s_data !== prev_data)) stab_viol++;
    if (s_valid && rdy && !fl) begin
      got_q.push_back(s_data);
      got_cyc.push_back(cyc);
    end
    prev_valid = s_valid;
    prev_data  = s_data;
    prev_pop   = s_valid && rdy;
    prev_fl    = fl;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    rst_a = 1'b0;
    flush = 1'b0;
    sif.m_ready = 1'b0;
    fifo_q.delete();
    n_loaded = n_read;
    repeat (2) @(negedge clk_a);
    rst_a = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    cyc = 0; first_rd = -1; first_vld = -1; max_count = 0; rd_cnt = 0;
    rd_viol = 0; stab_viol = 0;
    prev_valid = 0; prev_pop = 0; prev_fl = 0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; flush = 1'b0; sif.m_ready = 1'b0;
    repeat (2) @(negedge clk_a);
    fifo_q.push_back(4'h5);
    n_loaded++;
    #1;
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", fifo_rd_en); end
    n_checks++; if (sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", sif.m_valid); end
    n_checks++; if (sif.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h expected 0", sif.m_data); end
    n_checks++; if (buf_count !== '0) begin n_fail++; $display("FAIL reset_buf_count: got %0d expected 0", buf_count); end
    do_reset();
  endtask

  task automatic test_streaming();
    do_reset();
    cycle(1'b1, 1'b0, 8);
    n_checks++; if (first_rd !== 0) begin n_fail++; $display("FAIL stream_first_rd: got %0d expected 0", first_rd); end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 0);
    n_checks++; if (first_vld - first_rd !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first_vld - first_rd); end
    n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, got_q[i], i + 1); end
      n_checks++; if (got_cyc[i] !== got_cyc[0] + i) begin n_fail++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    n_checks++; if (max_count > 1) begin n_fail++; $display("FAIL stream_max_count: got %0d expected <=1", max_count); end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] first_word;
    do_reset();
    first_word = next_word;
    cycle(1'b0, 1'b0, 6);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 0);
    n_checks++; if (rd_cnt !== 3) begin n_fail++; $display("FAIL bp_reads: got %0d expected 3", rd_cnt); end
    n_checks++; if (s_count !== CW'(3)) begin n_fail++; $display("FAIL bp_buf_count: got %0d expected 3", s_count); end
    n_checks++; if (s_data !== first_word) begin n_fail++; $display("FAIL bp_m_data: got %0h expected %0h", s_data, first_word); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol); end
    cycle(1'b1, 1'b0, 0);
    n_checks++; if (s_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_held: got %0b expected 0", s_rd_en); end
    cycle(1'b1, 1'b0, 0);
    n_checks++; if (s_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_rd_resume: got %0b expected 1", s_rd_en); end
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 0);
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1'b0, 1'b0, 4);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    n_checks++; if (s_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en: got %0b expected 0", s_rd_en); end
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %0b expected 1", s_valid); end
    cycle(1'b1, 1'b0, 0);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL flush_m_valid: got %0b expected 0", s_valid); end
    n_checks++; if (s_count !== '0) begin n_fail++; $display("FAIL flush_buf_count: got %0d expected 0", s_count); end
    n_checks++; if (s_rd_en !== 1'b1) begin n_fail++; $display("FAIL flush_rd_resume: got %0b expected 1", s_rd_en); end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
    // The buffered word and the in-flight word are both discarded.
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL flush_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL flush_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] pattern;
    do_reset();
    pattern = 24'b1011_0110_0101_1100_1001_1010;
    cycle(1'b0, 1'b0, 10);
    for (int i = 0; i < 24; i++) cycle(pattern[i], 1'b0, 0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0);
    n_checks++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL wrap_stable: got %0d violations expected 0", stab_viol); end
  endtask

  task automatic test_random_ready();
    int loaded, guard, nl;
    do_reset();
    loaded = 0;
    guard = 0;
    while ((loaded < 200 || got_q.size() < 200) && guard < 3000) begin
      nl = 0;
      if (loaded < 200 && $urandom_range(0, 3) != 0) nl = int'($urandom_range(1, 2));
      if (nl > 200 - loaded) nl = 200 - loaded;
      loaded += nl;
      cycle(1'($urandom_range(0, 1)), 1'b0, nl);
      guard++;
    end
    n_checks++; if (got_q.size() !== 200) begin n_fail++; $display("FAIL rand_count: got %0d expected 200", got_q.size()); end
    for (int i = 0; i < 200 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (rd_viol !== 0) begin n_fail++; $display("FAIL rand_rd_when_empty: got %0d expected 0", rd_viol); end
    n_checks++; if (rd_empty_viol !== 0) begin n_fail++; $display("FAIL rand_fifo_underflow: got %0d expected 0", rd_empty_viol); end
    n_checks++; if (max_count > 3) begin n_fail++; $display("FAIL rand_max_count: got %0d expected <=3", max_count); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand_stable: got %0d violations expected 0", stab_viol); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] w;
    do_reset();
    cycle(1'b0, 1'b0, 5);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);
    n_checks++; if (s_count !== CW'(2)) begin n_fail++; $display("FAIL arst_pre_count: got %0d expected 2", s_count); end
    #2;
    rst_a = 1'b0;
    fifo_q.delete();
    n_loaded = n_read;
    #1;
    n_checks++; if (sif.m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_m_valid: got %0b expected 0", sif.m_valid); end
    n_checks++; if (sif.m_data !== '0) begin n_fail++; $display("FAIL arst_m_data: got %0h expected 0", sif.m_data); end
    n_checks++; if (buf_count !== '0) begin n_fail++; $display("FAIL arst_buf_count: got %0d expected 0", buf_count); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_rd_en: got %0b expected 0", fifo_rd_en); end
    @(negedge clk_a);
    rst_a = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    cyc = 0; first_rd = -1; first_vld = -1;
    prev_valid = 0; prev_pop = 0; prev_fl = 0;
    w = next_word;
    cycle(1'b1, 1'b0, 1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 0);
    n_checks++; if (first_vld - first_rd !== 2) begin n_fail++; $display("FAIL arst_latency: got %0d expected 2", first_vld - first_rd); end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL arst_count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== w) begin n_fail++; $display("FAIL arst_data: got %0h expected %0h", got_q[0], w); end
  endtask

  initial begin
    rst_a = 1'b0;
    flush = 1'b0;
    sif.m_ready = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_wrap();
    test_random_ready();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
